// File: rtl/two_phase_sync_responder.sv
// Two-phase req/ack responder: synchronizes req, hands each event to a valid/ready
// consumer, toggles ack after an optional delay. TWO_PHASE_RSP_PROTO_CHK_EN adds a protocol checker.
module two_phase_sync_responder #(
  parameter int ACK_DELAY = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic             ack,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [CNT_W-1:0] ev_count,
  output logic             busy,
  output logic             proto_err
);

  typedef enum logic [1:0] {IDLE, SIGNAL, HOLD} state_t;

  localparam logic [7:0] DLY = 8'(ACK_DELAY);

  state_t           state_q, state_d;
  logic             req_m_q, req_s_q;
  logic             ack_q, ack_d;
  logic             ev_valid_q, ev_valid_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       dly_q, dly_d;

  always_comb begin
    state_d    = state_q;
    ack_d      = ack_q;
    ev_valid_d = ev_valid_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    dly_d      = dly_q;
    case (state_q)
      IDLE: begin
        if (req_s_q != ack_q) begin
          state_d    = SIGNAL;
          ev_valid_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      SIGNAL: begin
        if (ev_valid_q && ev_ready) begin
          ev_valid_d = 1'b0;
          if (ACK_DELAY == 0) begin
            ack_d   = ~ack_q;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            dly_d   = DLY;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        dly_d = dly_q - 8'd1;
        // counter hits zero on this edge: complete the handshake
        if (dly_q == 8'd1) begin
          ack_d   = ~ack_q;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        ev_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_m_q    <= 1'b0;
      req_s_q    <= 1'b0;
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      ev_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      dly_q      <= '0;
    end else begin
      req_m_q    <= req;
      req_s_q    <= req_m_q;
      state_q    <= state_d;
      ack_q      <= ack_d;
      ev_valid_q <= ev_valid_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      dly_q      <= dly_d;
    end
  end

  assign ack      = ack_q;
  assign ev_valid = ev_valid_q;
  assign busy     = busy_q;
  assign ev_count = cnt_q;

`ifdef TWO_PHASE_RSP_PROTO_CHK_EN
  logic req_s_dly_q, req_s_dly_d;
  logic proto_err_q, proto_err_d;

  // a req_s change while an event is still open means req toggled again before ack
  always_comb begin
    req_s_dly_d = req_s_q;
    proto_err_d = proto_err_q;
    if ((state_q != IDLE) && (req_s_q != req_s_dly_q))
      proto_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_s_dly_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      req_s_dly_q <= req_s_dly_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule
